carpisma_denetleyici: RTL and testbench

Registered collision supervisor that sits directly downstream of the two-vehicle direction/collision decoder. Each cycle it samples both vehicles' 2-bit direction codes and the combinational `carpisti_mi` flag, and filters out glitches by requiring the flag for a programmable number of consecutive cycles. On a confirmed collision it forces both vehicles to a stop code for a fixed hold period, then keeps them stopped until the flag clears. It also raises a one-cycle alarm and keeps a saturating collision count.

---
 rtl/carpisma_pkg.sv | 21 ++
 rtl/doyan_sayac.sv | 29 ++
 rtl/carpisma_denetleyici.sv | 121 ++++++++++++
 tb/tb_carpisma_denetleyici.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/carpisma_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : carpisma_pkg                                               |
// | Description : Shared types and constants for the collision supervisor.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package carpisma_pkg;

    typedef enum logic [1:0] {
        SURUS = 2'd0,
        SUPHE = 2'd1,
        DUR   = 2'd2,
        TEMIZ = 2'd3
    } durum_t;

    typedef logic [1:0] yon_t;

    localparam yon_t c_DUR_KODU = 2'b00;

endpackage
`default_nettype wire

// File: rtl/doyan_sayac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : doyan_sayac                                                |
// | Description : Saturating up-counter with synchronous active-low clear.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module doyan_sayac #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] sayi
);

    logic [WIDTH-1:0] r_sayi;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sayi <= '0;
        end else if (inc && (r_sayi != {WIDTH{1'b1}})) begin
            r_sayi <= r_sayi + 1'b1;
        end
    end

    assign sayi = r_sayi;

endmodule
`default_nettype wire

// File: rtl/carpisma_denetleyici.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : carpisma_denetleyici                                       |
// | Description : Debounced collision supervisor: stops both vehicles for a  |
// |               fixed hold, then until the collision flag clears.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module carpisma_denetleyici
    import carpisma_pkg::*;
#(
    parameter int   ONAY_CYC  = 4,
    parameter int   BEKLE_CYC = 16,
    parameter int   SAYAC_W   = 8,
    parameter yon_t DUR_KODU  = c_DUR_KODU
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               yon_solbit1,
    input  logic               yon_sagbit1,
    input  logic               yon_solbit2,
    input  logic               yon_sagbit2,
    input  logic               carpisti_mi,
    output logic [1:0]         cikis_yon1,
    output logic [1:0]         cikis_yon2,
    output logic               durdur,
    output logic               alarm,
    output logic [SAYAC_W-1:0] carpisma_sayisi,
    output logic [1:0]         durum
);

    localparam int c_ONAY_W  = (ONAY_CYC  > 1) ? $clog2(ONAY_CYC)  : 1;
    localparam int c_BEKLE_W = (BEKLE_CYC > 1) ? $clog2(BEKLE_CYC) : 1;
    localparam logic [c_ONAY_W-1:0]  c_ONAY_SON  = c_ONAY_W'(ONAY_CYC - 1);
    localparam logic [c_BEKLE_W-1:0] c_BEKLE_SON = c_BEKLE_W'(BEKLE_CYC - 1);

    yon_t                 r_yon1;
    yon_t                 r_yon2;
    logic                 r_carp;
    durum_t               r_durum;
    logic [c_ONAY_W-1:0]  r_onay_cnt;
    logic [c_BEKLE_W-1:0] r_bekle_cnt;
    logic                 r_alarm;
    logic                 w_dur_giris;

    // Confirmation completes on this edge; drives both the alarm and the count.
    assign w_dur_giris = r_carp &&
                         (((r_durum == SURUS) && (ONAY_CYC == 1)) ||
                          ((r_durum == SUPHE) && (r_onay_cnt == c_ONAY_SON)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_yon1      <= 2'b00;
            r_yon2      <= 2'b00;
            r_carp      <= 1'b0;
            r_durum     <= SURUS;
            r_onay_cnt  <= '0;
            r_bekle_cnt <= '0;
            r_alarm     <= 1'b0;
        end else begin
            r_yon1  <= {yon_solbit1, yon_sagbit1};
            r_yon2  <= {yon_solbit2, yon_sagbit2};
            r_carp  <= carpisti_mi;
            r_alarm <= w_dur_giris;
            case (r_durum)
                SURUS: begin
                    if (r_carp) begin
                        if (ONAY_CYC == 1) begin
                            r_durum     <= DUR;
                            r_bekle_cnt <= c_BEKLE_SON;
                        end else begin
                            r_durum    <= SUPHE;
                            r_onay_cnt <= c_ONAY_W'(1);
                        end
                    end
                end
                SUPHE: begin
                    if (!r_carp) begin
                        r_durum    <= SURUS;
                        r_onay_cnt <= '0;
                    end else if (r_onay_cnt == c_ONAY_SON) begin
                        r_durum     <= DUR;
                        r_onay_cnt  <= '0;
                        r_bekle_cnt <= c_BEKLE_SON;
                    end else begin
                        r_onay_cnt <= r_onay_cnt + 1'b1;
                    end
                end
                DUR: begin
                    if (r_bekle_cnt == '0) begin
                        r_durum <= TEMIZ;
                    end else begin
                        r_bekle_cnt <= r_bekle_cnt - 1'b1;
                    end
                end
                TEMIZ: begin
                    if (!r_carp) begin
                        r_durum <= SURUS;
                    end
                end
                default: r_durum <= SURUS;
            endcase
        end
    end

    doyan_sayac #(
        .WIDTH (SAYAC_W)
    ) u_sayac (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_dur_giris),
        .sayi  (carpisma_sayisi)
    );

    assign durum      = r_durum;
    assign durdur     = r_durum[1];
    assign alarm      = r_alarm;
    assign cikis_yon1 = durdur ? DUR_KODU : r_yon1;
    assign cikis_yon2 = durdur ? DUR_KODU : r_yon2;

endmodule
`default_nettype wire

// File: tb/tb_carpisma_denetleyici.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_carpisma_denetleyici                                    |
// | Description : Randomized bench for two supervisor configurations.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_carpisma_denetleyici;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic yon_solbit1 = 1'b0, yon_sagbit1 = 1'b0;
    logic yon_solbit2 = 1'b0, yon_sagbit2 = 1'b0;
    logic carpisti_mi = 1'b0;

    logic [1:0] a_yon1, a_yon2, a_durum, b_yon1, b_yon2, b_durum;
    logic       a_durdur, a_alarm, b_durdur, b_alarm;
    logic [7:0] a_sayi;
    logic [1:0] b_sayi;

    int toplam = 0;
    int hatali = 0;

    always #5 clk = ~clk;

    carpisma_denetleyici u_dut_a (
        .clk (clk), .rst_n (rst_n),
        .yon_solbit1 (yon_solbit1), .yon_sagbit1 (yon_sagbit1),
        .yon_solbit2 (yon_solbit2), .yon_sagbit2 (yon_sagbit2),
        .carpisti_mi (carpisti_mi),
        .cikis_yon1 (a_yon1), .cikis_yon2 (a_yon2),
        .durdur (a_durdur), .alarm (a_alarm),
        .carpisma_sayisi (a_sayi), .durum (a_durum)
    );

    carpisma_denetleyici #(
        .ONAY_CYC (1), .BEKLE_CYC (3), .SAYAC_W (2)
    ) u_dut_b (
        .clk (clk), .rst_n (rst_n),
        .yon_solbit1 (yon_solbit1), .yon_sagbit1 (yon_sagbit1),
        .yon_solbit2 (yon_solbit2), .yon_sagbit2 (yon_sagbit2),
        .carpisti_mi (carpisti_mi),
        .cikis_yon1 (b_yon1), .cikis_yon2 (b_yon2),
        .durdur (b_durdur), .alarm (b_alarm),
        .carpisma_sayisi (b_sayi), .durum (b_durum)
    );

    // Reference: consecutive-sample streak, remaining stop cycles, stopped flag.
    int onay [2]  = '{4, 1};
    int bekle [2] = '{16, 3};
    int cmax [2]  = '{255, 3};
    int m_streak [2];
    int m_hold [2];
    int m_cnt [2];
    bit m_stop [2];
    bit m_alarm [2];
    bit m_pc;
    int m_y1, m_y2;

    task automatic kontrol(input string tag, input int obs, input int exp);
        toplam++;
        if (obs != exp) begin
            hatali++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_streak[k] = 0; m_hold[k] = 0; m_cnt[k] = 0;
                m_stop[k] = 0; m_alarm[k] = 0;
            end
            m_pc = 0; m_y1 = 0; m_y2 = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_alarm[k] = 0;
                if (!m_stop[k]) begin
                    m_streak[k] = m_pc ? m_streak[k] + 1 : 0;
                    if (m_streak[k] == onay[k]) begin
                        m_stop[k] = 1; m_hold[k] = bekle[k]; m_alarm[k] = 1;
                        m_streak[k] = 0;
                        if (m_cnt[k] < cmax[k]) m_cnt[k]++;
                    end
                end else if (m_hold[k] > 0) begin
                    m_hold[k]--;
                end else if (!m_pc) begin
                    m_stop[k] = 0;
                end
            end
            m_pc = carpisti_mi;
            m_y1 = {yon_solbit1, yon_sagbit1};
            m_y2 = {yon_solbit2, yon_sagbit2};
        end
    endtask

    function automatic int exp_durum(input int k);
        if (m_stop[k]) return (m_hold[k] > 0) ? 2 : 3;
        return (m_streak[k] > 0) ? 1 : 0;
    endfunction

    task automatic check_all();
        kontrol("A.durum",  a_durum,  exp_durum(0));
        kontrol("A.durdur", a_durdur, m_stop[0]);
        kontrol("A.alarm",  a_alarm,  m_alarm[0]);
        kontrol("A.sayi",   a_sayi,   m_cnt[0]);
        kontrol("A.yon1",   a_yon1,   m_stop[0] ? 0 : m_y1);
        kontrol("A.yon2",   a_yon2,   m_stop[0] ? 0 : m_y2);
        kontrol("B.durum",  b_durum,  exp_durum(1));
        kontrol("B.durdur", b_durdur, m_stop[1]);
        kontrol("B.alarm",  b_alarm,  m_alarm[1]);
        kontrol("B.sayi",   b_sayi,   m_cnt[1]);
        kontrol("B.yon1",   b_yon1,   m_stop[1] ? 0 : m_y1);
        kontrol("B.yon2",   b_yon2,   m_stop[1] ? 0 : m_y2);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_dirs();
        {yon_solbit1, yon_sagbit1, yon_solbit2, yon_sagbit2} = 4'($urandom);
    endtask

    int p;
    int guard;

    initial begin
        // Reset held with the flag and all direction bits high.
        @(negedge clk);
        rst_n = 0; carpisti_mi = 1;
        {yon_solbit1, yon_sagbit1, yon_solbit2, yon_sagbit2} = 4'b1111;
        cycle();
        cycle();
        kontrol("rst.a_durum", a_durum, 0);
        kontrol("rst.a_yon1", a_yon1, 0);
        kontrol("rst.a_sayi", a_sayi, 0);

        rst_n = 1; carpisti_mi = 0;
        for (int i = 0; i < 4; i++) begin rand_dirs(); cycle(); end

        // Drive dut A into DUR and reset it partway through the hold.
        carpisti_mi = 1;
        guard = 0;
        while (!(m_stop[0] && m_hold[0] == bekle[0] - 4) && guard < 40) begin
            rand_dirs(); cycle(); guard++;
        end
        kontrol("middur.reached", guard < 40, 1);
        rst_n = 0;
        cycle();
        kontrol("middur.a_durum", a_durum, 0);
        kontrol("middur.a_durdur", a_durdur, 0);
        kontrol("middur.a_sayi", a_sayi, 0);
        rst_n = 1; carpisti_mi = 0;
        for (int i = 0; i < 5; i++) begin rand_dirs(); cycle(); end

        // Randomized traffic with changing collision density.
        p = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 64 == 0) begin
                case ($urandom_range(0, 3))
                    0: p = 5;
                    1: p = 40;
                    2: p = 80;
                    default: p = 97;
                endcase
            end
            carpisti_mi = ($urandom_range(0, 99) < p);
            rst_n = ($urandom_range(0, 499) != 0);
            rand_dirs();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", toplam, hatali);
        $finish;
    end

endmodule
`default_nettype wire
